// File: rtl/riscv_pkg.sv
// riscv_pkg: shared hazard-controller state, pipeline control bundle and defaults
package riscv_pkg;
  localparam int HAZ_MDU_TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} hazard_state_t;
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating stall, flush-event and MDU-wait cycle counters
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_evt,
  input  logic             flush_evt,
  input  logic             mdu_evt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] mdu_cycles
);
  // each counter sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
      mdu_cycles   <= '0;
    end else begin
      if (stall_evt && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
      if (flush_evt && ~&flush_events) flush_events <= flush_events + 1'b1;
      if (mdu_evt && ~&mdu_cycles) mdu_cycles <= mdu_cycles + 1'b1;
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl import riscv_pkg::*; #(
  parameter int MDU_TIMEOUT = HAZ_MDU_TIMEOUT_DEF
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_redirect,
  input  logic       ex_mdu_start,
  input  logic       mdu_done,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       mdu_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_events
  , output logic [CNT_W-1:0] mdu_cycles
`endif
);
  localparam int TW = $clog2(MDU_TIMEOUT + 1);
  hazard_state_t state, state_n;
  logic done_pending, done_pending_n, ret_mdu, ret_mdu_n, block, block_n, err, err_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic mem_busy, mdu_active, mdu_op, mdu_fin, mdu_wait, timeout, load_use;
  pipe_ctrl_t ctrl, q;
  assign mem_busy   = (mem_req || state == MEM_WAIT) && !mem_ready;
  assign mdu_active = state == MDU_WAIT || (state == MEM_WAIT && ret_mdu);
  assign mdu_op     = mdu_active || (ex_mdu_start && !block);
  assign mdu_fin    = mdu_done || done_pending;
  assign mdu_wait   = mdu_op && !mdu_fin;
  assign timeout    = state == MDU_WAIT && !mdu_fin && tcnt == TW'(MDU_TIMEOUT - 1);
  assign load_use   = ex_mem_read && ex_rd_addr != 5'd0 &&
                      ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                       (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
  // state, MDU bookkeeping and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      done_pending <= 1'b0;
      ret_mdu      <= 1'b0;
      block        <= 1'b0;
      err          <= 1'b0;
      tcnt         <= '0;
    end else begin
      state        <= state_n;
      done_pending <= done_pending_n;
      ret_mdu      <= ret_mdu_n;
      block        <= block_n;
      err          <= err_n;
      tcnt         <= tcnt_n;
    end
  end
  // prioritised decode: mem wait > MDU timeout/wait > redirect > load-use
  always_comb begin
    ctrl           = '0;
    state_n        = RUN;
    done_pending_n = 1'b0;
    ret_mdu_n      = 1'b0;
    block_n        = 1'b0;
    err_n          = err;
    tcnt_n         = tcnt;
    if (mem_busy) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
      state_n           = MEM_WAIT;
      ret_mdu_n         = mdu_active;
      done_pending_n    = done_pending || (mdu_done && mdu_active);
    end else if (timeout) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
      err_n             = 1'b1;
      block_n           = 1'b1;
    end else if (mdu_wait) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
      state_n           = MDU_WAIT;
      tcnt_n            = state == MDU_WAIT ? tcnt + 1'b1 : (mdu_active ? tcnt : '0);
    end else begin
      block_n           = mdu_op;
      ctrl.if_id_flush  = ex_redirect;
      ctrl.id_ex_flush  = ex_redirect || load_use;
      ctrl.pc_stall     = !ex_redirect && load_use;
      ctrl.if_id_stall  = !ex_redirect && load_use;
    end
  end
  assign q               = rst ? '0 : ctrl;
  assign pc_stall        = q.pc_stall;
  assign if_id_stall     = q.if_id_stall;
  assign if_id_flush     = q.if_id_flush;
  assign id_ex_stall     = q.id_ex_stall;
  assign id_ex_flush     = q.id_ex_flush;
  assign ex_mem_stall    = q.ex_mem_stall;
  assign ex_mem_flush    = q.ex_mem_flush;
  assign mem_wb_flush    = q.mem_wb_flush;
  assign mdu_timeout_err = err && !rst;
  a_no_stall_and_flush: assert property (@(posedge clk) disable iff (rst)
    !(q.if_id_stall && q.if_id_flush) && !(q.id_ex_stall && q.id_ex_flush) &&
    !(q.ex_mem_stall && q.ex_mem_flush));
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_evt    (q.pc_stall),
    .flush_evt    (q.if_id_flush || q.id_ex_flush),
    .mdu_evt      (!rst && state == MDU_WAIT),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .mdu_cycles   (mdu_cycles)
  );
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives hold and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards, taken branches and jumps, multi-cycle MDU operations in EX, and data-memory wait states.
- Sits beside the pipeline registers in the core top level. Its stall outputs feed register enables; its flush outputs feed the registers' existing flush inputs.

Parameters:
- MDU_TIMEOUT, 64: maximum cycles in MDU_WAIT before abort and error.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_rs1_addr  in  5  rs1 of the instruction in ID
- id_rs2_addr  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd_addr  in  5  rd of the instruction in EX
- ex_redirect  in  1  taken branch or jump resolved in EX
- ex_mdu_start  in  1  EX holds a multi-cycle MUL/DIV op (level, held while in EX)
- mdu_done  in  1  one-cycle pulse, MDU result valid
- mem_req  in  1  MEM stage has an active dmem access
- mem_ready  in  1  dmem access completes this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  bubble IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  bubble ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- ex_mem_flush  out  1  bubble EX/MEM
- mem_wb_flush  out  1  bubble MEM/WB
- mdu_timeout_err  out  1  sticky error flag

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=RUN, done_pending=0, timeout counter=0, mdu_timeout_err=0.
  - All outputs are 0 during and after reset.
  - Reset mid-MDU_WAIT or mid-MEM_WAIT returns to RUN next cycle and drops all stalls.
- Output decode: stall/flush outputs are combinational from state and inputs. Zero added latency: a hazard seen in cycle N controls the clock edge ending cycle N.
- Priority, highest first: mem wait > MDU wait > redirect > load-use.
- States and transitions:
  - RUN → MEM_WAIT when mem_req && !mem_ready.
  - RUN → MDU_WAIT when ex_mdu_start.
  - MDU_WAIT → RUN when mdu_done or done_pending.
  - MEM_WAIT → RUN on mem_ready, unless the MDU is still busy (see below).
- MEM_WAIT actions:
  - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush; redirect and load-use flushes are suppressed.
  - On the cycle mem_ready is seen, drop the stalls that cycle and return to RUN.
  - If entered from MDU_WAIT with the MDU still busy, return to MDU_WAIT instead.
- MDU_WAIT actions:
  - Assert pc_stall, if_id_stall, id_ex_stall and ex_mem_flush.
  - A mdu_done pulse arriving while in MEM_WAIT sets done_pending; done_pending is cleared on exit to RUN.
  - On the done cycle, stalls drop and the state returns to RUN.
  - ex_mdu_start is ignored for one cycle after exit, so a completed op is not restarted.
- Timeout:
  - Counter increments each MDU_WAIT cycle and clears on entry.
  - On reaching MDU_TIMEOUT-1: set mdu_timeout_err (sticky until rst), return to RUN, and pulse id_ex_flush to discard the op.
- Redirect (RUN, no higher-priority event): assert if_id_flush and id_ex_flush.
  - PC update is owned by the fetch logic; pc_stall=0.
  - A redirect held frozen in EX by a stall acts on the first unstalled cycle.
- Load-use (RUN, no redirect):
  - Hazard condition: ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr)).
  - Action: one cycle of pc_stall, if_id_stall and id_ex_flush. It cannot repeat, because the load leaves EX.
- Invariant: a stage's stall and flush are never both asserted in the same cycle (assertion required).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output ports stall_cycles, flush_events and mdu_cycles, each CNT_W wide.
  - stall_cycles: counts cycles with pc_stall=1.
  - flush_events: counts cycles with if_id_flush or id_ex_flush=1.
  - mdu_cycles: counts cycles in MDU_WAIT.
  - All three saturate at all-ones and reset to 0.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- riscv_pkg adds:
  - hazard_state_t enum {RUN, MDU_WAIT, MEM_WAIT}.
  - pipe_ctrl_t packed struct grouping the stall/flush bits.
  - HAZ_MDU_TIMEOUT_DEF constant.
- Sub-module hazard_perf_cnt holds the three counters. It is instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_uses_rs2=1 → exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1; next cycle all 0.
- rd=x0: same as above with ex_rd_addr=0 → no stall.
- Redirect plus load-use in the same cycle → if_id_flush=id_ex_flush=1, pc_stall=0.
- MDU: ex_mdu_start=1, mdu_done after 10 cycles → pc_stall high for 11 cycles, ex_mem_flush high throughout, RUN after the done cycle.
- mdu_done during a MEM_WAIT of 3 cycles (mem_ready low for 3 cycles) → done_pending=1; on mem_ready the state goes to RUN with no hang.
- MDU_TIMEOUT=8 and mdu_done never asserted → mdu_timeout_err=1 after 8 cycles, one-cycle id_ex_flush, stalls clear; err stays 1 until rst=1.
